// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch program-counter sequencer: FSM states, redirect causes
// and the cause priority helper (trap > jalr > jal > taken branch).
package pc_seq_pkg;

  localparam int DEFAULT_ADDR_W = 16;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    BR   = 3'd1,
    JAL  = 3'd2,
    JALR = 3'd3,
    TRAP = 3'd4
  } cause_e;

  function automatic cause_e pick_cause(input logic trap_en, input logic jalr_en,
                                        input logic jal_en, input logic br_taken);
    cause_e c;
    if (trap_en) begin
      c = TRAP;
    end else if (jalr_en) begin
      c = JALR;
    end else if (jal_en) begin
      c = JAL;
    end else if (br_taken) begin
      c = BR;
    end else begin
      c = NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Redirect cause selection and word-index target arithmetic; every target wraps
// modulo 2^ADDR_W and the low two byte-offset bits are dropped.
module pc_target_calc
  import pc_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   jalr_base,
  input  logic [XLEN-1:0]   trap_vec,
  input  logic              br_taken,
  input  logic              jal_en,
  input  logic              jalr_en,
  input  logic              trap_en,
  output logic              redirect,
  output logic [ADDR_W-1:0] target
);

  cause_e            cause_s;
  logic [XLEN-1:0]   imm_sra_s;
  logic [XLEN-1:0]   jalr_sum_s;
  logic [ADDR_W-1:0] rel_tgt_s;
  logic              unused_bits_s;

  // imm is a byte offset; an arithmetic shift turns it into a signed word offset.
  assign imm_sra_s  = $signed(imm) >>> 2'd2;
  assign rel_tgt_s  = ex_pc[ADDR_W-1:0] + imm_sra_s[ADDR_W-1:0];
  assign jalr_sum_s = jalr_base + imm;

  assign unused_bits_s = ^{ex_pc[XLEN-1:ADDR_W], imm_sra_s[XLEN-1:ADDR_W],
                           jalr_sum_s[XLEN-1:ADDR_W+2], jalr_sum_s[1:0],
                           trap_vec[XLEN-1:ADDR_W]};

  // Highest-priority cause selects the target; lower causes are ignored.
  always_comb begin
    cause_s  = pick_cause(trap_en, jalr_en, jal_en, br_taken);
    redirect = (cause_s != NONE);
    case (cause_s)
      TRAP:    target = trap_vec[ADDR_W-1:0];
      JALR:    target = jalr_sum_s[ADDR_W+1:2];
      JAL, BR: target = rel_tgt_s;
      default: target = {ADDR_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with BOOT/RUN/BUBBLE sequencing and prioritised redirects.
// Optional performance counters are built when PC_PERF_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int RESET_PC = 0,
  parameter int BUBBLES  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic            br_taken,
  input  logic            jal_en,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_vec,
  output logic            flush,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     stall_cnt
);

  localparam logic [ADDR_W-1:0] RESET_IDX = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(1'b1);
  localparam logic [2:0]        BUB_LOAD  = 3'(BUBBLES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              redirect_s;
  logic              take_s;
  logic [ADDR_W-1:0] target_s;

  pc_target_calc #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_target (
    .ex_pc     (ex_pc),
    .imm       (imm),
    .jalr_base (jalr_base),
    .trap_vec  (trap_vec),
    .br_taken  (br_taken),
    .jal_en    (jal_en),
    .jalr_en   (jalr_en),
    .trap_en   (trap_en),
    .redirect  (redirect_s),
    .target    (target_s)
  );

  // Redirects resolving while still booting are not acted on.
  assign take_s = redirect_s && (state_q != BOOT);

  // Next-state logic: redirect beats an accepted fetch; bubbles count down to RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (take_s) begin
          pc_d    = target_s;
          flush_d = 1'b1;
          if (BUB_LOAD != 3'd0) begin
            state_d = BUBBLE;
            cnt_d   = BUB_LOAD;
          end else begin
            state_d = RUN;
          end
        end else if (fetch_ready) begin
          pc_d = pc_q + PC_STEP;
        end else begin
          pc_d = pc_q;
        end
      end
      BUBBLE: begin
        if (take_s) begin
          pc_d    = target_s;
          flush_d = 1'b1;
          cnt_d   = BUB_LOAD;
        end else if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_IDX;
        cnt_d   = 3'd0;
      end
    endcase
    fetch_valid_d = (state_d == RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_IDX;
      cnt_q         <= 3'd0;
      flush_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
  assign pc          = {{(XLEN-ADDR_W){1'b0}}, pc_q};

`ifdef PC_PERF_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Event counters wrap naturally at 2^32.
  always_comb begin
    if (take_s) begin
      redirect_cnt_d = redirect_cnt_q + 32'd1;
    end else begin
      redirect_cnt_d = redirect_cnt_q;
    end
    if ((state_q == RUN) && !fetch_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  assign redirect_cnt = 32'd0;
  assign stall_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the fetch PC rules.
module tb_pc_sequencer;

  localparam int BUBBLES = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] pc;
  logic [31:0] ex_pc, imm, jalr_base, trap_vec;
  logic        br_taken, jal_en, jalr_en, trap_en;
  logic        flush;
  logic [31:0] redirect_cnt, stall_cnt;

  int vectors = 0;
  int miscompares = 0;

`ifdef PC_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  // Reference model state
  logic [15:0] m_pc;
  bit          m_boot;
  int          m_wait;
  bit          m_flush;
  int unsigned m_redirects, m_stalls;

  pc_sequencer #(.XLEN(32), .ADDR_W(16), .RESET_PC(0), .BUBBLES(BUBBLES)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .pc(pc), .ex_pc(ex_pc), .imm(imm), .br_taken(br_taken), .jal_en(jal_en),
    .jalr_en(jalr_en), .jalr_base(jalr_base), .trap_en(trap_en), .trap_vec(trap_vec),
    .flush(flush), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_target();
    longint off, t;
    if (trap_en) begin
      t = longint'(trap_vec);
    end else if (jalr_en) begin
      t = ((longint'(jalr_base) + longint'($signed(imm))) & 64'hFFFF_FFFF) / 4;
    end else begin
      off = longint'($signed(imm));
      off = (off >= 0) ? off / 4 : -((-off + 3) / 4);
      t = longint'(ex_pc) + off;
    end
    t = t % 65536;
    if (t < 0) t = t + 65536;
    return 16'(t);
  endfunction

  task automatic model_reset();
    m_pc = 16'd0; m_boot = 1'b1; m_wait = 0; m_flush = 1'b0;
    m_redirects = 0; m_stalls = 0;
  endtask

  task automatic clear_redirects();
    br_taken = 1'b0; jal_en = 1'b0; jalr_en = 1'b0; trap_en = 1'b0;
  endtask

  // Advance one clock: model consumes the same inputs the DUT sees at the edge.
  task automatic tick();
    bit fetching, rd;
    fetching = !m_boot && (m_wait == 0);
    rd = !m_boot && (trap_en || jalr_en || jal_en || br_taken);
    if (fetching && !fetch_ready) m_stalls++;
    if (m_boot) begin
      m_boot = 1'b0; m_flush = 1'b0;
    end else if (rd) begin
      m_pc = ref_target(); m_flush = 1'b1; m_wait = BUBBLES; m_redirects++;
    end else begin
      m_flush = 1'b0;
      if (m_wait > 0) m_wait--;
      else if (fetch_ready) m_pc = m_pc + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_redirects();
    fetch_ready = 1'b1;
    ex_pc = 32'd0; imm = 32'd0; jalr_base = 32'd0; trap_vec = 32'd0;
    rst_n = 1'b0;
    model_reset();
    #12;
    vectors += 4;
    if (pc !== 32'd0) begin miscompares++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'd0); end
    if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
    if (flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush got=%b exp=0", flush); end
    if (redirect_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      miscompares++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", redirect_cnt, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    vectors++;
    if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL boot_valid got=%b exp=0", fetch_valid); end
    tick();
    vectors += 2;
    if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL run_valid got=%b exp=1", fetch_valid); end
    if (pc !== 32'd0) begin miscompares++; $display("FAIL seq_pc0 got=%h exp=0", pc); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (pc !== 32'(i)) begin miscompares++; $display("FAIL seq_pc got=%h exp=%h", pc, 32'(i)); end
    end
  endtask

  task automatic test_branch();
    ex_pc = 32'd10; imm = -32'sd8; br_taken = 1'b1;
    tick();
    clear_redirects();
    vectors += 3;
    if (flush !== 1'b1) begin miscompares++; $display("FAIL br_flush got=%b exp=1", flush); end
    if (pc !== 32'd8) begin miscompares++; $display("FAIL br_pc got=%h exp=%h", pc, 32'd8); end
    if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL br_bubble got=%b exp=0", fetch_valid); end
    tick();
    vectors += 3;
    if (flush !== 1'b0) begin miscompares++; $display("FAIL br_flush_end got=%b exp=0", flush); end
    if (fetch_valid !== 1'b1 || pc !== 32'd8) begin
      miscompares++; $display("FAIL br_resume got=%b/%h exp=1/%h", fetch_valid, pc, 32'd8);
    end
    tick();
    if (pc !== 32'd9) begin miscompares++; $display("FAIL br_next got=%h exp=%h", pc, 32'd9); end
  endtask

  task automatic test_priority();
    trap_vec = 32'h40; ex_pc = 32'h100; imm = 32'h20; jalr_base = 32'h800;
    trap_en = 1'b1; jal_en = 1'b1; br_taken = 1'b1;
    tick();
    clear_redirects();
    vectors += 2;
    if (pc !== 32'h40) begin miscompares++; $display("FAIL prio_pc got=%h exp=%h", pc, 32'h40); end
    if (flush !== 1'b1) begin miscompares++; $display("FAIL prio_flush got=%b exp=1", flush); end
    jalr_en = 1'b1; jal_en = 1'b1;
    tick();
    clear_redirects();
    vectors++;
    if (pc !== {16'd0, m_pc}) begin miscompares++; $display("FAIL prio_jalr got=%h exp=%h", pc, {16'd0, m_pc}); end
    tick();
  endtask

  task automatic test_wrap();
    trap_vec = 32'h0000_FFFF; trap_en = 1'b1;
    tick();
    clear_redirects();
    tick();
    vectors++;
    if (pc !== 32'h0000_FFFF || fetch_valid !== 1'b1) begin
      miscompares++; $display("FAIL wrap_top got=%h/%b exp=%h/1", pc, fetch_valid, 32'h0000_FFFF);
    end
    tick();
    vectors++;
    if (pc !== 32'd0) begin miscompares++; $display("FAIL wrap_inc got=%h exp=0", pc); end
    ex_pc = 32'd1; imm = -32'sd16; br_taken = 1'b1;
    tick();
    clear_redirects();
    vectors++;
    if (pc !== 32'h0000_FFFD) begin miscompares++; $display("FAIL wrap_back got=%h exp=%h", pc, 32'h0000_FFFD); end
    tick();
  endtask

  task automatic test_stall();
    fetch_ready = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (pc !== 32'd0 || fetch_valid !== 1'b1) begin
        miscompares++; $display("FAIL stall_hold got=%h/%b exp=0/1", pc, fetch_valid);
      end
    end
    vectors += 2;
    if (stall_cnt !== (PERF_ON ? 32'd5 : 32'd0)) begin
      miscompares++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, PERF_ON ? 5 : 0);
    end
    if (redirect_cnt !== 32'd0) begin miscompares++; $display("FAIL stall_rcnt got=%0d exp=0", redirect_cnt); end
    fetch_ready = 1'b1;
  endtask

  task automatic test_bubble_redirect_reset();
    ex_pc = 32'h20; imm = 32'h10; br_taken = 1'b1;
    tick();
    clear_redirects();
    vectors++;
    if (pc !== 32'h24 || fetch_valid !== 1'b0) begin
      miscompares++; $display("FAIL bub_first got=%h/%b exp=%h/0", pc, fetch_valid, 32'h24);
    end
    jalr_base = 32'h400; imm = 32'h8; jalr_en = 1'b1;
    tick();
    clear_redirects();
    vectors += 2;
    if (pc !== 32'h102 || flush !== 1'b1) begin
      miscompares++; $display("FAIL bub_redir got=%h/%b exp=%h/1", pc, flush, 32'h102);
    end
    if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL bub_reload got=%b exp=0", fetch_valid); end
    rst_n = 1'b0;
    model_reset();
    #2;
    vectors += 2;
    if (pc !== 32'd0 || fetch_valid !== 1'b0 || flush !== 1'b0) begin
      miscompares++; $display("FAIL bub_rst got=%h/%b/%b exp=0/0/0", pc, fetch_valid, flush);
    end
    if (redirect_cnt !== 32'd0) begin miscompares++; $display("FAIL bub_rst_cnt got=%0d exp=0", redirect_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (pc !== 32'd0 || fetch_valid !== 1'b1) begin
      miscompares++; $display("FAIL bub_boot got=%h/%b exp=0/1", pc, fetch_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      fetch_ready = ($urandom_range(0, 3) != 0);
      trap_en  = ($urandom_range(0, 15) == 0);
      jalr_en  = ($urandom_range(0, 9) == 0);
      jal_en   = ($urandom_range(0, 9) == 0);
      br_taken = ($urandom_range(0, 7) == 0);
      ex_pc = $urandom; imm = $urandom; jalr_base = $urandom; trap_vec = $urandom;
      if ($urandom_range(0, 1) == 0) imm = 32'($signed(12'($urandom)));
      tick();
      vectors += 5;
      if (pc !== {16'd0, m_pc}) begin miscompares++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", c, pc, {16'd0, m_pc}); end
      if (fetch_valid !== (!m_boot && m_wait == 0)) begin
        miscompares++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, fetch_valid, !m_boot && m_wait == 0);
      end
      if (flush !== m_flush) begin miscompares++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", c, flush, m_flush); end
      if (redirect_cnt !== (PERF_ON ? m_redirects : 32'd0)) begin
        miscompares++; $display("FAIL rnd_rcnt cyc=%0d got=%0d exp=%0d", c, redirect_cnt, PERF_ON ? m_redirects : 0);
      end
      if (stall_cnt !== (PERF_ON ? m_stalls : 32'd0)) begin
        miscompares++; $display("FAIL rnd_scnt cyc=%0d got=%0d exp=%0d", c, stall_cnt, PERF_ON ? m_stalls : 0);
      end
    end
    clear_redirects();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_wrap();
    test_stall();
    test_bubble_redirect_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
